// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
//
// Buffers a list of 4-bit cube move codes and feeds them one at a time to the
// six-face stepper datapath. It sits between the solver/UART move source and
// the stepper datapath. NULL codes (4'hF) are skipped silently, codes 0, 1 and
// 14 are skipped and flagged, and a mechanical settle gap separates moves.
//
// Handshakes (valid/ready semantics, one place):
//   - Enqueue: a write happens on a rising clock edge where
//     move_in_valid && move_in_ready. move_in_ready is "FIFO not full"; a write
//     offered while full is simply not taken (no error). A write offered in a
//     cycle where the FIFO is being flushed is discarded.
//   - Issue: next_move is presented and move_start pulses high for exactly one
//     cycle. next_move is held stable until the sequencer leaves WAIT.
//   - Completion: move_done is the datapath "idle" level. It is ignored for
//     BLANK_CYCLES cycles after move_start, then sampled each cycle in WAIT.
//
// Parameters:
//   DEPTH          FIFO entries, power of two, 2..256
//   BLANK_CYCLES   cycles after move_start during which move_done is ignored (>=1)
//   SETTLE_CYCLES  idle gap after move_done before the next issue (>=1)
//   TIMEOUT_CYCLES max cycles in WAIT before a timeout error (>=1)
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   move_in[3:0]     move code to enqueue
//   move_in_valid    enqueue strobe
//   move_in_ready    FIFO not full
//   go               1-cycle pulse: start executing queued moves (ignored while busy)
//   abort            1-cycle pulse: flush FIFO, return to IDLE after current move
//   next_move[3:0]   move code to the datapath, 4'hF when idle
//   move_start       1-cycle pulse to the datapath
//   move_done        datapath idle (AND of all face done flags)
//   busy             state != IDLE
//   fifo_count       queued entries
//   error[1:0]       sticky: [0] invalid code seen, [1] WAIT timeout
//   moves_done_cnt   (only with MOVE_SEQ_COUNT_EN) moves that left WAIT on
//                    move_done; wraps at 16'hFFFF, cleared only by reset
//   state_dbg[2:0]   current FSM state encoding, for observation
//
// Optional feature macro: MOVE_SEQ_COUNT_EN
// -----------------------------------------------------------------------------
module move_sequencer #(
  parameter int DEPTH          = 32,
  parameter int BLANK_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               move_in,
  input  logic                     move_in_valid,
  output logic                     move_in_ready,
  input  logic                     go,
  input  logic                     abort,
  output logic [3:0]               next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               error,
`ifdef MOVE_SEQ_COUNT_EN
  output logic [15:0]              moves_done_cnt,
`endif
  output logic [2:0]               state_dbg
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_BS  = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
  localparam int MAX_LIM = (MAX_BS > TIMEOUT_CYCLES) ? MAX_BS : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_LIM + 1);

  // A phase of N cycles ends in the cycle where the counter reads N-1.
  localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(DEPTH);

  localparam logic [3:0] NULL_CODE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_BLANK  = 3'd3,
    S_WAIT   = 3'd4,
    S_SETTLE = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            abort_pend;

  // FIFO storage and pointers. DEPTH is a power of two, so the pointers wrap
  // modulo DEPTH by plain binary overflow.
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [3:0]      head;
  logic            fifo_empty;

  // Control strobes from the next-state logic.
  logic            pop;
  logic            flush;
  logic            latch_move;
  logic            set_invalid;
  logic            set_timeout;
  logic            wr_en;
  logic            in_flight;
  logic            abort_seen;

  assign head          = mem[rd_ptr];
  assign fifo_empty    = (count == '0);
  assign move_in_ready = (count != FULL_COUNT);
  assign wr_en         = move_in_valid && move_in_ready && !flush;
  assign fifo_count    = count;

  // States where a move has been (or is being) handed to the motor; an abort
  // there must wait for the move to finish instead of flushing at once.
  assign in_flight  = (state == S_ISSUE) || (state == S_BLANK) ||
                      (state == S_WAIT)  || (state == S_SETTLE);
  assign abort_seen = abort_pend || abort;

  assign move_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    flush       = 1'b0;
    latch_move  = 1'b0;
    set_invalid = 1'b0;
    set_timeout = 1'b0;

    case (state)
      S_IDLE: begin
        // Abort takes priority over a coincident go: nothing is started.
        if (abort) begin
          flush = 1'b1;
        end else if (go) begin
          state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        if (abort) begin
          flush   = 1'b1;
          state_n = S_IDLE;
        end else if (fifo_empty) begin
          state_n = S_IDLE;
        end else begin
          pop = 1'b1;
          if (head == NULL_CODE) begin
            state_n = S_FETCH;
          end else if ((head == 4'd0) || (head == 4'd1) || (head == 4'd14)) begin
            set_invalid = 1'b1;
            state_n     = S_FETCH;
          end else begin
            latch_move = 1'b1;
            state_n    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        state_n = S_BLANK;
      end

      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (move_done) begin
          state_n = S_SETTLE;
          // A pending abort flushes the queue as the move completes.
          if (abort_seen) begin
            flush = 1'b1;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          set_timeout = 1'b1;
          flush       = 1'b1;
          state_n     = S_IDLE;
        end
      end

      S_SETTLE: begin
        // The motor is already stopped here, so an abort can flush at once.
        if (abort) begin
          flush = 1'b1;
        end
        if (cnt == SETTLE_LAST) begin
          state_n = abort_seen ? S_IDLE : S_FETCH;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state, phase counter, abort latch, error flags, next_move
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      abort_pend <= 1'b0;
      error      <= 2'b00;
      next_move  <= NULL_CODE;
    end else begin
      state <= state_n;

      // The counter only runs inside a timed phase and restarts on every
      // state change, so it never exceeds the largest phase length.
      if ((state_n != state) ||
          !((state == S_BLANK) || (state == S_WAIT) || (state == S_SETTLE))) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      abort_pend <= (abort_pend || (abort && in_flight)) && (state_n != S_IDLE);

      error <= error | {set_timeout, set_invalid};

      if ((state_n == S_IDLE) && (state != S_IDLE)) begin
        next_move <= NULL_CODE;
      end else if (latch_move) begin
        next_move <= head;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous write and pop leave the occupancy unchanged.
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= move_in;
    end
  end

`ifdef MOVE_SEQ_COUNT_EN
  // ---------------------------------------------------------------------------
  // Completed-move counter: moves that left WAIT because move_done was seen.
  // Abort does not clear it; 16-bit overflow wraps to zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      moves_done_cnt <= 16'd0;
    end else if ((state == S_WAIT) && move_done) begin
      moves_done_cnt <= moves_done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
//
// Bench for move_sequencer with DEPTH=4, BLANK_CYCLES=4, SETTLE_CYCLES=10,
// TIMEOUT_CYCLES=100. A datapath model drops move_done on the cycle of
// move_start and raises it 20 cycles later (or never, in hang mode).
// Expected move codes go into exp_q when enqueued and are compared against
// next_move on every move_start. Expected issue/idle cycle numbers come from
// a small timing model of the FETCH/ISSUE/BLANK/WAIT/SETTLE sequence.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

  localparam int DEPTH   = 4;
  localparam int BLANK   = 4;
  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 100;
  localparam int DONE_LOW = 20;

  // One issued move, when back-to-back: ISSUE + BLANK + WAIT until move_done
  // + SETTLE + the FETCH cycle that picks the next code.
  localparam int MOVE_PERIOD = 1 + BLANK + (DONE_LOW - BLANK) + SETTLE + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                    clock;
  logic                    reset;
  logic [3:0]              move_in;
  logic                    move_in_valid;
  logic                    move_in_ready;
  logic                    go;
  logic                    abort;
  logic [3:0]              next_move;
  logic                    move_start;
  logic                    move_done;
  logic                    busy;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [1:0]              error;
  logic [2:0]              state_dbg;
`ifdef MOVE_SEQ_COUNT_EN
  logic [15:0]             moves_done_cnt;
`endif

  move_sequencer #(
    .DEPTH         (DEPTH),
    .BLANK_CYCLES  (BLANK),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .move_in       (move_in),
    .move_in_valid (move_in_valid),
    .move_in_ready (move_in_ready),
    .go            (go),
    .abort         (abort),
    .next_move     (next_move),
    .move_start    (move_start),
    .move_done     (move_done),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .error         (error),
`ifdef MOVE_SEQ_COUNT_EN
    .moves_done_cnt(moves_done_cnt),
`endif
    .state_dbg     (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Datapath model
  // ---------------------------------------------------------------------------
  bit hang = 1'b0;
  int low_cnt = 0;
  initial move_done = 1'b1;

  always @(negedge clock) begin
    if (reset) begin
      move_done = 1'b1;
      low_cnt   = 0;
    end else if (move_start) begin
      move_done = 1'b0;
      low_cnt   = DONE_LOW;
    end else if (low_cnt > 0) begin
      low_cnt = low_cnt - 1;
      if (low_cnt == 0 && !hang) move_done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [3:0] exp_q[$];
  int         start_q[$];

  always @(negedge clock) begin
    if (!reset && move_start) begin
      logic [3:0] e;
      start_q.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_move_start: next_move=%h, no move expected (cycle %0d)",
                 next_move, cyc);
      end else begin
        e = exp_q.pop_front();
        if (next_move !== e) begin
          n_fail++;
          $display("FAIL next_move: got %h, expected %h (cycle %0d)", next_move, e, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered and left at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset         = 1'b1;
    move_in       = 4'h0;
    move_in_valid = 1'b0;
    go            = 1'b0;
    abort         = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    start_q.delete();
    @(negedge clock);
  endtask

  function automatic bit is_move(input logic [3:0] c);
    return (c >= 4'd2) && (c <= 4'd13);
  endfunction

  function automatic bit is_bad(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd14);
  endfunction

  task automatic enq(input logic [3:0] code, input bit expect_issue);
    move_in       = code;
    move_in_valid = 1'b1;
    if (expect_issue) exp_q.push_back(code);
    @(negedge clock);
    move_in_valid = 1'b0;
  endtask

  task automatic pulse_go(output int g);
    go = 1'b1;
    g  = cyc;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_idle(output int c, input int bound);
    bit seen = 1'b0;
    c = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clock);
      if (!busy) begin
        seen = 1'b1;
        c    = cyc;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", bound);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: three codes per row, expected issue count and error
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] codes [3];
    int         n_starts;
    logic [1:0] err;
  } vec_t;

  localparam int NROWS = 7;
  vec_t vecs [NROWS];

  task automatic set_row(input int r, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [3:0] c2, input int n, input logic [1:0] e);
    vecs[r].codes[0] = c0;
    vecs[r].codes[1] = c1;
    vecs[r].codes[2] = c2;
    vecs[r].n_starts = n;
    vecs[r].err      = e;
  endtask

  // Enqueue a row, run it, and compare issue order, issue cycles, idle cycle,
  // error and final outputs. Does not reset, so it can be chained.
  task automatic run_row(input int r);
    int g, idle_c, t, n;
    int exp_start[$];
    for (int i = 0; i < 3; i++) enq(vecs[r].codes[i], is_move(vecs[r].codes[i]));
    check($sformatf("row%0d_fifo_count", r), fifo_count, 3);
    start_q.delete();
    pulse_go(g);
    // Timing model: FETCH takes a cycle per popped code; a real move adds
    // a full issue period before the next FETCH.
    t = g + 1;
    for (int i = 0; i < 3; i++) begin
      if (is_move(vecs[r].codes[i])) begin
        exp_start.push_back(t + 1);
        t = t + MOVE_PERIOD;
      end else begin
        t = t + 1;
      end
    end
    wait_idle(idle_c, 500);
    check($sformatf("row%0d_n_starts", r), start_q.size(), vecs[r].n_starts);
    n = (start_q.size() < exp_start.size()) ? start_q.size() : exp_start.size();
    for (int i = 0; i < n; i++)
      check($sformatf("row%0d_start%0d_cycle", r, i), start_q[i], exp_start[i]);
    check($sformatf("row%0d_idle_cycle", r), idle_c, t + 1);
    check($sformatf("row%0d_error", r), error, vecs[r].err);
    check($sformatf("row%0d_next_move_idle", r), next_move, 4'hF);
    check($sformatf("row%0d_fifo_empty", r), fifo_count, 0);
    check($sformatf("row%0d_exp_q_drained", r), exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int g, idle_c, s;
    bit found;

    set_row(0, 4'd2,  4'd5,  4'd13, 3, 2'b00);
    set_row(1, 4'd15, 4'd0,  4'd6,  1, 2'b01);
    set_row(2, 4'd14, 4'd15, 4'd1,  0, 2'b01);
    set_row(3, 4'd7,  4'd15, 4'd12, 2, 2'b00);
    set_row(4, 4'd3,  4'd14, 4'd15, 1, 2'b01);
    for (int r = 5; r < NROWS; r++) begin
      vecs[r].n_starts = 0;
      vecs[r].err      = 2'b00;
      for (int i = 0; i < 3; i++) begin
        vecs[r].codes[i] = 4'($urandom_range(0, 15));
        if (is_move(vecs[r].codes[i])) vecs[r].n_starts++;
        if (is_bad(vecs[r].codes[i]))  vecs[r].err = 2'b01;
      end
    end

    // Reset values.
    do_reset();
    check("reset_next_move",  next_move, 4'hF);
    check("reset_move_start", move_start, 0);
    check("reset_busy",       busy, 0);
    check("reset_error",      error, 0);
    check("reset_ready",      move_in_ready, 1);
    check("reset_fifo_count", fifo_count, 0);

    // Table rows.
    for (int r = 0; r < NROWS; r++) begin
      do_reset();
      run_row(r);
    end

    // Full FIFO: fifth write dropped without error.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_ready_before_write%0d", i), move_in_ready, (i < DEPTH) ? 1 : 0);
      enq(4'(2 + i), i < DEPTH);
    end
    check("full_fifo_count", fifo_count, DEPTH);
    check("full_ready",      move_in_ready, 0);
    check("full_error",      error, 0);
    pulse_go(g);
    wait_idle(idle_c, 1000);
    check("full_n_starts", start_q.size(), DEPTH);
    check("full_exp_q_drained", exp_q.size(), 0);

    // Write and pop in the same cycle keep fifo_count unchanged.
    do_reset();
    enq(4'd2, 1'b1);
    enq(4'd3, 1'b1);
    pulse_go(g);
    enq(4'd8, 1'b1);          // lands on the FETCH cycle that pops code 2
    check("wr_rd_same_cycle_count", fifo_count, 2);
    wait_idle(idle_c, 500);
    check("wr_rd_n_starts", start_q.size(), 3);

    // Abort in IDLE flushes at once and discards a simultaneous write.
    do_reset();
    enq(4'd4, 1'b0);
    enq(4'd5, 1'b0);
    abort         = 1'b1;
    move_in       = 4'd6;
    move_in_valid = 1'b1;
    @(negedge clock);
    abort         = 1'b0;
    move_in_valid = 1'b0;
    check("abort_idle_fifo_count", fifo_count, 0);
    check("abort_idle_busy", busy, 0);
    pulse_go(g);
    wait_idle(idle_c, 50);
    check("abort_idle_no_starts", start_q.size(), 0);

    // Timeout: move_done never returns.
    do_reset();
    hang = 1'b1;
    enq(4'd3, 1'b1);
    enq(4'd4, 1'b0);
    pulse_go(g);
    wait_idle(idle_c, 400);
    check("timeout_n_starts", start_q.size(), 1);
    if (start_q.size() > 0)
      check("timeout_idle_cycle", idle_c - start_q[0], 1 + BLANK + TIMEOUT);
    check("timeout_error", error, 2'b10);
    check("timeout_fifo_flushed", fifo_count, 0);
    check("timeout_next_move", next_move, 4'hF);
    hang = 1'b0;

    // Abort during the first WAIT: move completes, queue flushed on SETTLE entry.
    do_reset();
    enq(4'd2, 1'b1);
    enq(4'd3, 1'b0);
    enq(4'd4, 1'b0);
    enq(4'd5, 1'b0);
    pulse_go(g);
    found = 1'b0;
    s     = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (move_start) begin
        found = 1'b1;
        s     = cyc;
      end else begin
        @(negedge clock);
      end
    end
    check("abort_wait_start_seen", found, 1);
    repeat (1 + BLANK) @(negedge clock);   // cycle s+5: first WAIT cycle
    check("abort_wait_in_wait", state_dbg, 3'd4);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_wait_deferred_flush", fifo_count, DEPTH - 1);
    while (cyc < s + DONE_LOW) @(negedge clock);
    check("abort_wait_still_queued", fifo_count, DEPTH - 1);
    @(negedge clock);
    check("abort_settle_flushed", fifo_count, 0);
    check("abort_settle_busy", busy, 1);
    wait_idle(idle_c, 200);
    check("abort_idle_cycle", idle_c - s, DONE_LOW + 1 + SETTLE);
    check("abort_n_starts", start_q.size(), 1);
    check("abort_error", error, 0);
    check("abort_next_move", next_move, 4'hF);

`ifdef MOVE_SEQ_COUNT_EN
    // Completed-move counter across two runs, cleared only by reset.
    do_reset();
    run_row(0);
    run_row(0);
    check("count_after_two_runs", moves_done_cnt, 6);
    do_reset();
    check("count_after_reset", moves_done_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
